// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered 8N1 UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int DATA_BITS            = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 1250;  // 12 MHz / 9600 baud

endpackage

// File: rtl/uart_tx_framer_if.sv
// Byte push handshake between upstream logic and the UART transmitter.
interface uart_tx_framer_if;

  logic [7:0] TX_BYTE;
  logic       TX_VALID;
  logic       TX_READY;

  modport master (output TX_BYTE, output TX_VALID, input  TX_READY);
  modport slave  (input  TX_BYTE, input  TX_VALID, output TX_READY);

endinterface

// File: rtl/uart_tx_fifo.sv
// DEPTH x 8 synchronous FIFO with count-based full/empty flags.
module uart_tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_push,
  input  logic [7:0] i_data,
  input  logic       i_pop,
  output logic [7:0] o_data,
  output logic       o_full,
  output logic       o_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [7:0]    r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == CW'(0));
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_data  = r_mem[r_rd_ptr];

  // storage array, data only, not cleared by reset
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // pointers and occupancy; simultaneous push and pop leaves count unchanged
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= PW'(0);
      r_rd_ptr <= PW'(0);
      r_count  <= CW'(0);
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_framer.sv
// Buffered 8N1 UART transmitter: FIFO-fed start/data/stop serialiser that
// chains queued frames with no idle gap.
module uart_tx_framer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DEPTH        = 4,
  parameter int STOP_BITS    = 1
) (
  input  logic              iCE_CLK,
  input  logic              RST,
  uart_tx_framer_if.slave   tx_if,
  output logic              TX,
  output logic              BUSY,
  output logic              TX_DONE
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_PRE  = BW'(CLKS_PER_BIT - 2);
  localparam logic [2:0]    IDX_LAST  = 3'(DATA_BITS - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

  tx_state_t     r_state;
  tx_state_t     w_state_next;
  logic [BW-1:0] r_baud;
  logic [BW-1:0] w_baud_next;
  logic [2:0]    r_idx;
  logic [2:0]    w_idx_next;
  logic [2:0]    w_idx_inc;
  logic [7:0]    r_shift;
  logic [7:0]    w_shift_next;
  logic          r_tx;
  logic          w_tx_next;
  logic          r_done;
  logic          w_done_next;
  logic          w_bit_end;
  logic          w_pop;
  logic          w_push;
  logic          w_full;
  logic          w_empty;
  logic [7:0]    w_fifo_data;

  assign w_push         = tx_if.TX_VALID & ~w_full;
  assign tx_if.TX_READY = ~w_full;
  assign TX             = r_tx;
  assign TX_DONE        = r_done;
  assign BUSY           = (r_state != IDLE) | ~w_empty;
  assign w_bit_end      = (r_baud == BAUD_LAST);
  assign w_idx_inc      = r_idx + 3'd1;

  uart_tx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk   (iCE_CLK),
    .i_rst   (RST),
    .i_push  (w_push),
    .i_data  (tx_if.TX_BYTE),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // next-state, baud/bit counters, shifter and line level
  always_comb begin
    w_state_next = r_state;
    w_baud_next  = r_baud;
    w_idx_next   = r_idx;
    w_shift_next = r_shift;
    w_tx_next    = r_tx;
    w_done_next  = 1'b0;
    w_pop        = 1'b0;
    case (r_state)
      IDLE: begin
        w_baud_next = BW'(0);
        w_idx_next  = 3'd0;
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_shift_next = w_fifo_data;
          w_tx_next    = 1'b0;
          w_state_next = START;
        end else begin
          w_tx_next    = 1'b1;
          w_state_next = IDLE;
        end
      end
      START: begin
        if (w_bit_end) begin
          w_baud_next  = BW'(0);
          w_idx_next   = 3'd0;
          w_tx_next    = r_shift[0];
          w_state_next = DATA;
        end else begin
          w_baud_next = r_baud + BW'(1);
        end
      end
      DATA: begin
        if (w_bit_end) begin
          w_baud_next = BW'(0);
          if (r_idx == IDX_LAST) begin
            w_idx_next   = 3'd0;
            w_tx_next    = 1'b1;
            w_state_next = STOP;
          end else begin
            w_idx_next = w_idx_inc;
            w_tx_next  = r_shift[w_idx_inc];
          end
        end else begin
          w_baud_next = r_baud + BW'(1);
        end
      end
      STOP: begin
        // in STOP the bit index counts stop bits; TX_DONE is raised one
        // cycle early so the registered pulse covers the final stop cycle
        if (w_bit_end) begin
          w_baud_next = BW'(0);
          if (r_idx == STOP_LAST) begin
            w_idx_next = 3'd0;
            if (!w_empty) begin
              w_pop        = 1'b1;
              w_shift_next = w_fifo_data;
              w_tx_next    = 1'b0;
              w_state_next = START;
            end else begin
              w_tx_next    = 1'b1;
              w_state_next = IDLE;
            end
          end else begin
            w_idx_next = w_idx_inc;
          end
        end else begin
          w_baud_next = r_baud + BW'(1);
          if ((r_baud == BAUD_PRE) && (r_idx == STOP_LAST)) begin
            w_done_next = 1'b1;
          end else begin
            w_done_next = 1'b0;
          end
        end
      end
      default: begin
        w_state_next = IDLE;
        w_tx_next    = 1'b1;
      end
    endcase
  end

  // state and datapath registers
  always_ff @(posedge iCE_CLK) begin
    if (RST) begin
      r_state <= IDLE;
      r_baud  <= BW'(0);
      r_idx   <= 3'd0;
      r_shift <= 8'd0;
      r_tx    <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_baud  <= w_baud_next;
      r_idx   <= w_idx_next;
      r_shift <= w_shift_next;
      r_tx    <= w_tx_next;
      r_done  <= w_done_next;
    end
  end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Self-checking bench: waveform-level reference model plus table and corner sequences.
module tb_uart_tx_framer;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_framer_if if0 ();
  uart_tx_framer_if if1 ();
  logic tx0, busy0, done0;
  logic tx1, busy1, done1;

  uart_tx_framer #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH), .STOP_BITS(1)) dut0 (
    .iCE_CLK(clk), .RST(rst), .tx_if(if0.slave),
    .TX(tx0), .BUSY(busy0), .TX_DONE(done0)
  );
  uart_tx_framer #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH), .STOP_BITS(2)) dut1 (
    .iCE_CLK(clk), .RST(rst), .tx_if(if1.slave),
    .TX(tx1), .BUSY(busy1), .TX_DONE(done1)
  );

  typedef struct {
    logic [7:0] data;
    logic [9:0] line;   // bit 0 = start, bits 1..8 = data LSB first, bit 9 = stop
  } vec_t;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // model: queued bytes and the remaining per-cycle line levels of the frame on the wire
  logic [7:0] mq [2][$];
  logic       mw [2][$];

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%b expected=%b", name, cyc, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_step(input int k, input int sb, input logic v, input logic [7:0] d);
    int pre_n;
    logic [7:0] b;
    if (rst) begin
      mq[k].delete();
      mw[k].delete();
    end else begin
      if (mw[k].size() > 0) void'(mw[k].pop_front());
      pre_n = mq[k].size();
      if (mw[k].size() == 0 && pre_n > 0) begin
        b = mq[k].pop_front();
        for (int i = 0; i < CPB; i++) mw[k].push_back(1'b0);
        for (int j = 0; j < 8; j++)
          for (int i = 0; i < CPB; i++) mw[k].push_back(b[j]);
        for (int i = 0; i < sb * CPB; i++) mw[k].push_back(1'b1);
      end
      if (v && pre_n < DEPTH) mq[k].push_back(d);
    end
  endtask

  task automatic check_dut(input int k, input string p, input logic tx, input logic busy,
                           input logic done, input logic ready);
    logic etx;
    etx = (mw[k].size() > 0) ? mw[k][0] : 1'b1;
    check({p, "_tx"}, tx, etx);
    check({p, "_busy"}, busy, (mw[k].size() > 0) || (mq[k].size() > 0));
    check({p, "_done"}, done, mw[k].size() == 1);
    check({p, "_ready"}, ready, mq[k].size() < DEPTH);
  endtask

  task automatic tick();
    model_step(0, 1, if0.TX_VALID, if0.TX_BYTE);
    model_step(1, 2, if1.TX_VALID, if1.TX_BYTE);
    @(posedge clk);
    @(negedge clk);
    cyc++;
    check_dut(0, "d0", tx0, busy0, done0, if0.TX_READY);
    check_dut(1, "d1", tx1, busy1, done1, if1.TX_READY);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((busy0 || busy1) && n < 1000) begin
      tick();
      n++;
    end
    check("drain_timeout", busy0 | busy1, 1'b0);
  endtask

  initial begin
    vec_t vecs[6];
    int c0, b, rel, ndone, last_done, acc6, first_done, zeros;
    logic rdy;

    vecs[0] = '{8'hA5, 10'b1101001010};
    vecs[1] = '{8'h00, 10'b1000000000};
    vecs[2] = '{8'hFF, 10'b1111111110};
    vecs[3] = '{8'h01, 10'b1000000010};
    vecs[4] = '{8'h80, 10'b1100000000};
    vecs[5] = '{8'h3C, 10'b1001111000};

    if0.TX_VALID = 1'b0; if0.TX_BYTE = 8'h00;
    if1.TX_VALID = 1'b0; if1.TX_BYTE = 8'h00;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check("rst_tx", tx0, 1'b1);
    check("rst_busy", busy0, 1'b0);
    check("rst_done", done0, 1'b0);
    check("rst_ready", if0.TX_READY, 1'b1);

    // idle after reset
    ndone = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (done0 || busy0 || !tx0) ndone++;
    end
    check_int("idle_activity", ndone, 0);

    // single-frame table
    for (int v = 0; v < 6; v++) begin
      if0.TX_VALID = 1'b1; if0.TX_BYTE = vecs[v].data;
      tick();
      c0 = cyc;
      if0.TX_VALID = 1'b0; if0.TX_BYTE = 8'h00;
      ndone = 0;
      for (int r = 1; r <= 44; r++) begin
        tick();
        rel = cyc - c0;
        if (rel % 4 == 3 && rel < 40) check("vec_bit", tx0, vecs[v].line[rel / 4]);
        if (done0) begin
          ndone++;
          check_int("vec_done_cycle", rel, 40);
        end
      end
      check_int("vec_done_count", ndone, 1);
      check("vec_end_busy", busy0, 1'b0);
      check("vec_end_tx", tx0, 1'b1);
    end

    // back-to-back burst 0x01..0x06 with VALID held
    b = 1; if0.TX_VALID = 1'b1; if0.TX_BYTE = 8'd1;
    c0 = cyc + 1; ndone = 0; last_done = 0; acc6 = 0; first_done = 0;
    for (int i = 0; i < 250; i++) begin
      rdy = if0.TX_READY;
      tick();
      if (done0) begin
        ndone++; last_done = cyc;
        if (first_done == 0) first_done = cyc;
      end
      if (rdy && if0.TX_VALID) begin
        if (b == 6) acc6 = cyc;
        b++;
        if (b > 6) if0.TX_VALID = 1'b0;
        else if0.TX_BYTE = 8'(b);
      end
    end
    check_int("burst_done_count", ndone, 6);
    check_int("burst_total", last_done - c0, 240);
    check_int("burst_acc6", acc6, first_done + 2);
    drain();

    // reset mid-frame, then a clean 0x00 frame
    if0.TX_VALID = 1'b1; if0.TX_BYTE = 8'hFF;
    tick();
    c0 = cyc;
    if0.TX_VALID = 1'b0;
    ndone = 0;
    while (cyc - c0 < 16) begin
      tick();
      if (done0) ndone++;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_tx", tx0, 1'b1);
    check("midrst_busy", busy0, 1'b0);
    check("midrst_ready", if0.TX_READY, 1'b1);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done0) ndone++;
    end
    check_int("midrst_no_done", ndone, 0);
    if0.TX_VALID = 1'b1; if0.TX_BYTE = 8'h00;
    tick();
    if0.TX_VALID = 1'b0;
    zeros = 0;
    for (int i = 0; i < 44; i++) begin
      tick();
      if (!tx0) zeros++;
    end
    check_int("midrst_zero_run", zeros, 36);
    check("midrst_end_tx", tx0, 1'b1);

    // two stop bits: 0x80 then 0x81
    if1.TX_VALID = 1'b1; if1.TX_BYTE = 8'h80;
    tick();
    c0 = cyc;
    if1.TX_BYTE = 8'h81;
    tick();
    if1.TX_VALID = 1'b0;
    ndone = 0; last_done = 0;
    for (int i = 0; i < 92; i++) begin
      tick();
      if (done1) begin ndone++; last_done = cyc; end
    end
    check_int("stop2_done_count", ndone, 2);
    check_int("stop2_total", last_done - c0, 88);

    // full FIFO while TX_BYTE toggles with VALID high
    if0.TX_VALID = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if0.TX_BYTE = 8'($urandom_range(0, 255));
      tick();
    end
    check("full_ready_low", if0.TX_READY, 1'b0);
    for (int i = 0; i < 30; i++) begin
      if0.TX_BYTE = 8'($urandom_range(0, 255));
      tick();
    end
    if0.TX_VALID = 1'b0;
    drain();

    // randomized traffic with occasional reset
    for (int i = 0; i < 3000; i++) begin
      if0.TX_VALID = ($urandom_range(0, 3) == 0);
      if0.TX_BYTE  = 8'($urandom_range(0, 255));
      if1.TX_VALID = ($urandom_range(0, 3) == 0);
      if1.TX_BYTE  = 8'($urandom_range(0, 255));
      rst = ($urandom_range(0, 599) == 0);
      tick();
    end
    rst = 1'b0;
    if0.TX_VALID = 1'b0;
    if1.TX_VALID = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_framer.md
Name: uart_tx_framer

Overview:
- Buffered 8N1 UART transmitter: the transmit-side counterpart of the board's UART receiver, driving the TX pin.
- Upstream logic pushes bytes over a valid/ready handshake into a small FIFO.
- A bit-timing state machine serialises each byte as start bit, 8 data bits LSB first, then stop bit(s), with no idle gap between queued frames.

Parameters:
- CLKS_PER_BIT, 1250, clock cycles per bit (12 MHz / 9600 baud); minimum 2.
- DEPTH, 4, FIFO entries; power of 2, minimum 2.
- STOP_BITS, 1, number of stop bits; 1 or 2.

Ports:
- iCE_CLK  input  1  system clock; all logic on rising edge.
- RST  input  1  reset, synchronous, active-high.
- TX_BYTE  input  8  byte to send; sampled on handshake.
- TX_VALID  input  1  TX_BYTE valid.
- TX_READY  output  1  FIFO can accept; equals not-full.
- TX  output  1  serial line, registered, idle high.
- BUSY  output  1  high when state is not IDLE or FIFO is non-empty.
- TX_DONE  output  1  one-cycle pulse at the end of each frame's last stop bit.

Behaviour:
- Reset (RST high at an edge): TX=1, TX_READY=1, BUSY=0, TX_DONE=0. FIFO flushed, state=IDLE, counters cleared. Reset mid-frame aborts the frame; TX is 1 from that edge.
- Push: TX_VALID & TX_READY at a rising edge writes TX_BYTE. With VALID high and READY low, no write occurs and TX_BYTE may change freely.
- Pop: uses the registered count only, so there is no same-cycle fall-through. Push and pop in one cycle are both honoured; count is unchanged.
- States:
  - IDLE: TX=1. If FIFO is non-empty, the next edge pops into the shift register, TX<=0, and the state goes to START.
  - START: hold 0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: 8 bits LSB first, each held CLKS_PER_BIT cycles; 3-bit index counts 0..7, then go to STOP.
  - STOP: TX=1 for STOP_BITS*CLKS_PER_BIT cycles.
- End of the last stop cycle: TX_DONE=1 for one cycle.
  - FIFO non-empty: pop and enter START on the same edge, so TX falls immediately with no gap.
  - FIFO empty: go to IDLE.
- Latency: byte accepted into an empty FIFO while IDLE at edge N; TX falls at edge N+1. Frame length is (9+STOP_BITS)*CLKS_PER_BIT cycles.
- Baud counter: counts 0..CLKS_PER_BIT-1 and wraps to 0 on every bit boundary. Width is clog2(CLKS_PER_BIT).
- FIFO pointers: clog2(DEPTH) bits with natural wrap. Count is clog2(DEPTH)+1 bits; full when count==DEPTH.

Decomposition:
- Package uart_pkg: state enum (IDLE, START, DATA, STOP), DATA_BITS=8, default CLKS_PER_BIT for 12 MHz/9600.
- Sub-module uart_tx_fifo (DEPTH x 8, synchronous, count-based full/empty), instantiated once.
- The FSM, baud counter and shifter live in uart_tx_framer.

Test Plan (CLKS_PER_BIT=4, DEPTH=4 unless noted):
1. Reset, then push 0xA5 once -> TX sequence 0|1,0,1,0,0,1,0,1|1, each level 4 cycles, starting one edge after the push. TX_DONE pulses once at cycle 40. BUSY falls afterwards; TX stays 1.
2. Hold TX_VALID with 0x01..0x06 presented in order -> 0x01..0x05 accepted on consecutive cycles (first pops immediately) and TX_READY drops. 0x06 is accepted only after the first pop following frame 1's TX_DONE. Six frames go out back-to-back, 240 cycles with no idle gap, data in order.
3. Push 0xFF, assert RST for 1 cycle at cycle 17 -> TX=1 from that edge, FIFO empty, BUSY=0, no TX_DONE. A following push of 0x00 produces a clean frame: 0 for 36 cycles, then 1.
4. STOP_BITS=2, push 0x80 then 0x81 -> each stop period is 8 cycles high, the second start bit follows directly, and total time is 88 cycles.
5. TX_READY low (FIFO full) while TX_BYTE toggles with VALID high -> no extra bytes transmitted; the queued contents are unchanged.
6. Idle for 1000 cycles after reset with VALID=0 -> TX=1, BUSY=0, TX_DONE=0 throughout.
